dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  access request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port DMWr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port DMCtrl  input  3  size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 = word.
REQ-008 SHALL have port Address  input  32  byte address.
REQ-009 SHALL have port DataWr  input  32  store data, right-aligned.
REQ-010 SHALL have port DataRd  output  32  extended load data; this is the data-memory input of the register writeback select.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse; DataRd is valid.
REQ-012 SHALL have port err  output  1  one-cycle pulse; misaligned access rejected.

Function
REQ-013 SHALL implement FSM states IDLE and RESP; handshake = req_valid && req_ready.
REQ-014 SHALL drive req_ready=1 in IDLE, 0 in RESP; RESP always returns to IDLE after one cycle.
REQ-015 SHALL, on an accepted load, move to RESP and drive extended data on DataRd with rd_valid=1 during RESP (latency 1 cycle).
REQ-016 SHALL, on an accepted store, write the enabled byte lanes at that edge, stay in IDLE, and produce no rd_valid.
REQ-017 SHALL index the array with Address[log2(DEPTH_WORDS)+1:2]; higher bits ignored (wrap-around modulo array size).
REQ-018 SHALL use byte lanes: byte -> lane Address[1:0]; half -> lanes {1,0} or {3,2} per Address[1]; word -> all four lanes.
REQ-019 SHALL sign-extend bytes/halves for 000/001 and zero-extend them for 100/101.
REQ-020 SHALL hold DataRd at its last value outside RESP; rd_valid and err are 0 except as pulsed.
REQ-021 SHALL let a store in the cycle after a load to the same word take effect without altering DataRd presented in RESP.

Reset
REQ-022 SHALL, on rst, set state IDLE, DataRd=0, rd_valid=0, err=0, req_ready=1 the following cycle.
REQ-023 SHALL not reset array contents.
REQ-024 SHALL abort a load whose RESP coincides with rst: rd_valid stays 0.
REQ-025 SHALL ignore req_valid in a cycle with rst high (no write, no response).

Configuration
REQ-026 SHALL honour macro DMEM_MISALIGN_TRAP_EN: defined -> half with Address[0]=1 or word with Address[1:0]!=0 is accepted but not performed (no write, no RESP), and err pulses for 1 cycle on the following cycle.
REQ-027 SHALL, without DMEM_MISALIGN_TRAP_EN, force alignment by ignoring the offending low address bits, and tie err to 0.

Structure
REQ-028 SHALL place DMCtrl encoding constants and the state enum typedef in shared package dmem_pkg.
REQ-029 SHALL implement load extraction/extension as sub-module dmem_load_ext (combinational: word, Address[1:0], DMCtrl -> DataRd value).

Verification
REQ-030 SHALL test: SW 0x8000_00F1 at 0x10, then LW 0x10 -> rd_valid 1 cycle later, DataRd=0x8000_00F1, req_ready low during RESP.
REQ-031 SHALL test: after REQ-030, LB 0x10 -> 0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1; LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000.
REQ-032 SHALL test: SB 0xAB at 0x11 over word 0x8000_00F1 -> LW 0x10 returns 0x8000_ABF1.
REQ-033 SHALL test: SW 0x1234_5678 at (DEPTH_WORDS*4)+0x10 -> LW 0x10 returns 0x1234_5678 (wrap).
REQ-034 SHALL test, macro defined: LW 0x13 -> err pulse next cycle, no rd_valid; SW 0xFFFF_FFFF at 0x12 -> word 0x10 unchanged; macro undefined: LW 0x13 returns word 0x10, err stays 0.
REQ-035 SHALL test: rst asserted in the RESP cycle of a load -> rd_valid 0, DataRd 0 next cycle, then LW 0x10 returns the stored value unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: DMCtrl size/sign codes, access FSM states and size decode helpers shared by the data memory unit
package dmem_pkg;
    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;
    typedef enum logic {IDLE, RESP} state_e;
    function automatic logic is_byte(input logic [2:0] c);
        return c == DM_B || c == DM_BU;
    endfunction
    function automatic logic is_half(input logic [2:0] c);
        return c == DM_H || c == DM_HU;
    endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: selects the addressed byte/half of a memory word and sign- or zero-extends it
// ports: word (raw memory word), off (byte offset), ctrl (DMCtrl size/sign), data (extended result)
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ctrl,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    // halves use only off[1] and words ignore off, so misaligned low bits drop out here
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        data = is_byte(ctrl) ? {{24{b[7] & ~ctrl[2]}}, b} :
               is_half(ctrl) ? {{16{h[15] & ~ctrl[2]}}, h} : word;
    end
endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data memory with one-cycle load response and byte-lane stores
// ports: clk, rst (sync, active high); req_valid/req_ready handshake; DMWr (1 = store); DMCtrl size/sign;
//        Address byte address; DataWr store data; DataRd extended load data; rd_valid load pulse; err misalign pulse
// optional: DMEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses and pulses err instead of aligning
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic [31:0] DataRd,
    output logic        rd_valid,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0] mem [DEPTH_WORDS];
    state_e state_q, state_d;
    logic [31:0] data_q, data_d, ld_data, wr_data;
    logic err_q, err_d, fire, mis, we;
    logic [3:0] be;
    logic [AW-1:0] idx;
    assign idx = Address[AW+1:2];
    dmem_load_ext u_ext (
        .word(mem[idx]),
        .off (Address[1:0]),
        .ctrl(DMCtrl),
        .data(ld_data)
    );
`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = is_half(DMCtrl) ? Address[0] : !is_byte(DMCtrl) && Address[1:0] != 2'b00;
`else
    assign mis = 1'b0;
`endif
    always_comb begin
        fire = req_valid && req_ready;
        we = fire && DMWr && !mis && !rst;
        be = is_byte(DMCtrl) ? 4'b0001 << Address[1:0] :
             is_half(DMCtrl) ? (Address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr_data = is_byte(DMCtrl) ? {4{DataWr[7:0]}} :
                  is_half(DMCtrl) ? {2{DataWr[15:0]}} : DataWr;
        state_d = (fire && !DMWr && !mis) ? RESP : IDLE;
        data_d = state_d == RESP ? ld_data : data_q;
        err_d = fire && mis;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end
    // array is deliberately left out of reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
    // a reset landing on the response cycle suppresses the pulse immediately
    assign req_ready = state_q == IDLE;
    assign rd_valid = state_q == RESP && !rst;
    assign err = err_q;
    assign DataRd = data_q;
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed and randomized checks of dmem_unit against a byte-array reference model
module tb_dmem_unit;
    localparam int DW = 1024;
    localparam int NB = DW * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, DMWr = 1'b0;
    logic req_ready, rd_valid, err;
    logic [2:0] DMCtrl = 3'b010;
    logic [31:0] Address = '0, DataWr = '0, DataRd;
    logic [7:0] mb [NB];
    int n_pass = 0, n_tot = 0;
    dmem_unit #(.DEPTH_WORDS(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address), .DataWr(DataWr),
        .DataRd(DataRd), .rd_valid(rd_valid), .err(err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic int sz(input logic [2:0] c);
        return (c == 3'd0 || c == 3'd4) ? 1 : (c == 3'd1 || c == 3'd5) ? 2 : 4;
    endfunction
    function automatic bit misal(input logic [31:0] a, input logic [2:0] c);
        return TRAP && (a % sz(c) != 0);
    endfunction
    function automatic int base(input logic [31:0] a, input logic [2:0] c);
        int b = int'(a % NB);
        return b - b % sz(c);
    endfunction
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] v = '0;
        int b = base(a, c), n = sz(c);
        for (int i = 0; i < n; i++) v = v | (32'(mb[b+i]) << (8*i));
        if (n < 4 && c != 3'd4 && c != 3'd5 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
        return v;
    endfunction
    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        int b = base(a, c);
        for (int i = 0; i < sz(c); i++) mb[b+i] = 8'(d >> (8*i));
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        check("st_ready", req_ready, 1);
        req_valid = 1; DMWr = 1; DMCtrl = c; Address = a; DataWr = d;
        @(posedge clk); #1;
        req_valid = 0;
        check("st_rd_valid", rd_valid, 0);
        check("st_err", err, misal(a, c));
        check("st_ready_after", req_ready, 1);
        if (!misal(a, c)) model_store(a, d, c);
        @(posedge clk); #1;
        check("st_err_clear", err, 0);
    endtask
    task automatic load(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] exp = model_load(a, c);
        check("ld_ready", req_ready, 1);
        req_valid = 1; DMWr = 0; DMCtrl = c; Address = a;
        @(posedge clk); #1;
        req_valid = 0;
        if (misal(a, c)) begin
            check("ld_mis_rd_valid", rd_valid, 0);
            check("ld_mis_err", err, 1);
            @(posedge clk); #1;
            check("ld_mis_err_clear", err, 0);
        end else begin
            check("ld_rd_valid", rd_valid, 1);
            check("ld_ready_resp", req_ready, 0);
            check("ld_data", DataRd, exp);
            check("ld_err", err, 0);
            @(posedge clk); #1;
            check("ld_rd_valid_end", rd_valid, 0);
            check("ld_data_hold", DataRd, exp);
            check("ld_ready_back", req_ready, 1);
        end
    endtask
    initial begin
        logic [31:0] a;
        logic [2:0] c;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_data", DataRd, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 1);
        for (int w = 0; w < 16; w++) store(32'(w * 4), $urandom, 3'b010);
        store(32'h10, 32'h8000_00F1, 3'b010);
        load(32'h10, 3'b010); check("lw_10", DataRd, 32'h8000_00F1);
        load(32'h10, 3'b000); check("lb_10", DataRd, 32'hFFFF_FFF1);
        load(32'h10, 3'b100); check("lbu_10", DataRd, 32'h0000_00F1);
        load(32'h12, 3'b001); check("lh_12", DataRd, 32'hFFFF_8000);
        load(32'h12, 3'b101); check("lhu_12", DataRd, 32'h0000_8000);
        store(32'h11, 32'h0000_00AB, 3'b000);
        load(32'h10, 3'b010); check("sb_merge", DataRd, 32'h8000_ABF1);
        store(32'(DW * 4 + 'h10), 32'h1234_5678, 3'b010);
        load(32'h10, 3'b010); check("wrap", DataRd, 32'h1234_5678);
        load(32'h13, 3'b010); check("lw_13", DataRd, 32'h1234_5678);
`ifdef DMEM_MISALIGN_TRAP_EN
        store(32'h12, 32'hFFFF_FFFF, 3'b010);
        load(32'h10, 3'b010); check("mis_sw_nowrite", DataRd, 32'h1234_5678);
`endif
        // store queued behind a load to the same word
        req_valid = 1; DMWr = 0; DMCtrl = 3'b010; Address = 32'h10;
        @(posedge clk); #1;
        DMWr = 1; DataWr = 32'hCAFE_0001;
        check("raw_resp_data", DataRd, 32'h1234_5678);
        check("raw_resp_ready", req_ready, 0);
        @(posedge clk); #1;
        check("raw_idle_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
        model_store(32'h10, 32'hCAFE_0001, 3'b010);
        check("raw_data_kept", DataRd, 32'h1234_5678);
        check("raw_no_rd_valid", rd_valid, 0);
        load(32'h10, 3'b010); check("raw_new", DataRd, 32'hCAFE_0001);
        // reset in the response cycle
        req_valid = 1; DMWr = 0; DMCtrl = 3'b010; Address = 32'h10;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort_pre", rd_valid, 1);
        rst = 1; #1;
        check("abort_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        check("abort_data", DataRd, 0);
        check("abort_rd_valid_after", rd_valid, 0);
        rst = 0;
        check("abort_ready", req_ready, 1);
        // request ignored while in reset
        rst = 1; req_valid = 1; DMWr = 1; DMCtrl = 3'b010; Address = 32'h10; DataWr = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        check("rst_req_rd_valid", rd_valid, 0);
        load(32'h10, 3'b010); check("rst_no_write", DataRd, 32'hCAFE_0001);
        for (int k = 0; k < 300; k++) begin
            a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 12);
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) store(a, $urandom, c);
            else load(a, c);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
